// File: rtl/kbd_pkg.sv
// Scancode constants and decoder state type shared by the PS/2 set-2 key decoder.
package kbd_pkg;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } kbd_state_t;

endpackage

// File: rtl/kbd_scancode_decoder.sv
// Turns the PS/2 set-2 byte stream into held levels for Space, Left and Right,
// tracking E0/F0 prefixes, swallowing the Pause (E1) sequence and abandoning stale prefixes.
module kbd_scancode_decoder
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 200_000,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       key_space,
    output logic       key_left,
    output logic       key_right,
    output logic       seq_error
);

    if (CLK_FREQ == 0 || TIMEOUT_CYCLES < 2 || PAUSE_SKIP < 1 || PAUSE_SKIP > 7) begin : g_param_check
        $error("kbd_scancode_decoder: unsupported parameter combination");
    end

    localparam int unsigned      TO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       SKIP_INIT = 3'(PAUSE_SKIP);

    kbd_state_t       r_state;
    kbd_state_t       w_state_nxt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [TO_W-1:0]  w_to_nxt;
    logic [2:0]       r_skip_cnt;
    logic [2:0]       w_skip_nxt;
    logic             r_key_space;
    logic             r_key_left;
    logic             r_key_right;
    logic             r_seq_error;
    logic             w_space_nxt;
    logic             w_left_nxt;
    logic             w_right_nxt;
    logic             w_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_to_cnt    <= '0;
            r_skip_cnt  <= '0;
            r_key_space <= 1'b0;
            r_key_left  <= 1'b0;
            r_key_right <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_to_cnt    <= w_to_nxt;
            r_skip_cnt  <= w_skip_nxt;
            r_key_space <= w_space_nxt;
            r_key_left  <= w_left_nxt;
            r_key_right <= w_right_nxt;
            r_seq_error <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to_cnt;
        w_skip_nxt  = r_skip_cnt;
        w_space_nxt = r_key_space;
        w_left_nxt  = r_key_left;
        w_right_nxt = r_key_right;
        w_err_nxt   = 1'b0;

        if (scan_valid) begin
            // A byte always clears the gap timer, even on the cycle the timer would expire.
            w_to_nxt = '0;
            case (r_state)
                ST_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        w_state_nxt = ST_BRK;
                    end else if (scan_code == SC_PAUSE) begin
                        w_state_nxt = ST_SKIP;
                        w_skip_nxt  = SKIP_INIT;
                    end else if (scan_code == SC_SPACE) begin
                        w_space_nxt = 1'b1;
                    end
                end
                ST_EXT: begin
                    w_state_nxt = ST_IDLE;
                    if (scan_code == SC_BRK) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (scan_code == SC_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (scan_code == SC_LEFT) begin
                        w_left_nxt = 1'b1;
                    end else if (scan_code == SC_RIGHT) begin
                        w_right_nxt = 1'b1;
                    end
                end
                ST_BRK: begin
                    w_state_nxt = ST_IDLE;
                    if (scan_code == SC_SPACE) begin
                        w_space_nxt = 1'b0;
                    end else if (scan_code == SC_EXT) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (scan_code == SC_BRK) begin
                        w_state_nxt = ST_BRK;
                    end
                end
                ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                    if (scan_code == SC_LEFT) begin
                        w_left_nxt = 1'b0;
                    end else if (scan_code == SC_RIGHT) begin
                        w_right_nxt = 1'b0;
                    end
                end
                ST_SKIP: begin
                    if (r_skip_cnt <= 3'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_skip_nxt  = '0;
                    end else begin
                        w_skip_nxt = r_skip_cnt - 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_skip_nxt  = '0;
                end
            endcase
        end else if (r_state != ST_IDLE) begin
            if (r_to_cnt == TO_LAST) begin
                w_state_nxt = ST_IDLE;
                w_to_nxt    = '0;
                w_skip_nxt  = '0;
                w_err_nxt   = 1'b1;
            end else begin
                w_to_nxt = r_to_cnt + 1'b1;
            end
        end
    end

    assign key_space = r_key_space;
    assign key_left  = r_key_left;
    assign key_right = r_key_right;
    assign seq_error = r_seq_error;

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// Bench for kbd_scancode_decoder: directed scenarios plus a random byte stream,
// every cycle compared against a prefix-flag/deadline reference model.
module tb_kbd_scancode_decoder;

    localparam int unsigned T = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       key_space;
    logic       key_left;
    logic       key_right;
    logic       seq_error;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pending-prefix flags, bytes left to swallow, absolute expiry cycle.
    bit      m_space, m_left, m_right, m_err;
    bit      m_ext, m_brk;
    int      m_skip;
    longint  m_cyc;
    longint  m_deadline;

    logic [7:0] pool [9] = '{8'h29, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h14, 8'h77};

    kbd_scancode_decoder #(
        .CLK_FREQ       (100_000_000),
        .TIMEOUT_CYCLES (T),
        .PAUSE_SKIP     (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .key_space  (key_space),
        .key_left   (key_left),
        .key_right  (key_right),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got=%b expected=%b", tag, m_cyc, got, exp);
        end
    endtask

    function automatic bit m_active();
        return m_ext || m_brk || (m_skip > 0);
    endfunction

    function automatic void m_clear_seq();
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_skip = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (!m_ext && !m_brk) begin
            case (b)
                8'hE0: m_ext = 1'b1;
                8'hF0: m_brk = 1'b1;
                8'hE1: m_skip = 7;
                8'h29: m_space = 1'b1;
                default: ;
            endcase
        end else if (m_ext && !m_brk) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b != 8'hE0) begin
                if (b == 8'h6B) m_left = 1'b1;
                if (b == 8'h74) m_right = 1'b1;
                m_clear_seq();
            end
        end else if (!m_ext && m_brk) begin
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b != 8'hF0) begin
                if (b == 8'h29) m_space = 1'b0;
                m_clear_seq();
            end
        end else begin
            if (b == 8'h6B) m_left = 1'b0;
            if (b == 8'h74) m_right = 1'b0;
            m_clear_seq();
        end
        if (m_active()) m_deadline = m_cyc + T;
    endfunction

    task automatic tick(input bit r, input bit v, input logic [7:0] b);
        rst        = r;
        scan_valid = v;
        scan_code  = v ? b : 8'($urandom);
        @(posedge clk);
        #1;
        m_cyc++;
        m_err = 1'b0;
        if (r) begin
            m_space = 1'b0;
            m_left  = 1'b0;
            m_right = 1'b0;
            m_clear_seq();
        end else if (v) begin
            model_byte(b);
        end else if (m_active() && m_cyc == m_deadline) begin
            m_clear_seq();
            m_err = 1'b1;
        end
        chk("key_space", key_space, m_space);
        chk("key_left",  key_left,  m_left);
        chk("key_right", key_right, m_right);
        chk("seq_error", seq_error, m_err);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        tick(1'b0, 1'b1, b);
    endtask

    initial begin
        rst        = 1'b1;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        m_cyc      = 0;
        m_deadline = 0;
        m_space    = 1'b0;
        m_left     = 1'b0;
        m_right    = 1'b0;
        m_err      = 1'b0;
        m_clear_seq();

        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
        chk("reset_space", key_space, 1'b0);

        // Space make then break, far apart.
        send(8'h29, 5);
        chk("space_make", key_space, 1'b1);
        send(8'hF0, 1000);
        send(8'h29, 0);
        chk("space_break", key_space, 1'b0);

        // Left and right together, then release left only.
        send(8'hE0, 3); send(8'h6B, 1);
        send(8'hE0, 2); send(8'h74, 0);
        chk("both_left", key_left, 1'b1);
        chk("both_right", key_right, 1'b1);
        send(8'hE0, 4); send(8'hF0, 1); send(8'h6B, 1);
        chk("rel_left", key_left, 1'b0);
        chk("keep_right", key_right, 1'b1);

        // Release right, then orphan E0 times out and the late 74 is ignored.
        send(8'hF0, 2); send(8'hE0, 0); send(8'h74, 0);
        send(8'hE0, 3);
        idle(T + 5);
        send(8'h74, 0);
        chk("tmo_right", key_right, 1'b0);

        // Pause sequence is swallowed; the trailing space is decoded.
        send(8'hE1, 3); send(8'h14, 0); send(8'h77, 1); send(8'hE1, 0);
        send(8'hF0, 2); send(8'h14, 0); send(8'hF0, 1); send(8'h77, 0);
        chk("pause_nokey", key_space, 1'b0);
        send(8'h29, 2);
        chk("pause_space", key_space, 1'b1);

        // Typematic space, then right held and released with F0 E0 order.
        for (int i = 0; i < 10; i++) send(8'h29, 100);
        send(8'hE0, 2); send(8'h74, 0);
        send(8'hF0, 2); send(8'hE0, 0); send(8'h74, 0);
        chk("brk_order_right", key_right, 1'b0);

        // Reset between E0 and 6B.
        send(8'hE0, 2);
        tick(1'b1, 1'b0, 8'h00);
        chk("rst_space", key_space, 1'b0);
        send(8'h6B, 0);
        chk("rst_orphan_left", key_left, 1'b0);

        // Byte arriving exactly on the expiry cycle wins over the timeout.
        send(8'hE0, 2);
        send(8'h6B, T - 1);
        chk("edge_left", key_left, 1'b1);

        // Random stream with gaps around the timeout boundary and sparse resets.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            int          gap;
            r = $urandom_range(0, 19);
            if (r < 12)      gap = int'($urandom_range(0, 3));
            else if (r < 18) gap = int'($urandom_range(4, 20));
            else             gap = int'($urandom_range(T - 2, T + 1));
            if ($urandom_range(0, 199) == 0) tick(1'b1, 1'b0, 8'h00);
            if ($urandom_range(0, 9) == 0) send(8'($urandom), gap);
            else send(pool[$urandom_range(0, 8)], gap);
        end
        idle(T + 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/kbd_scancode_decoder.md
Name: kbd_scancode_decoder

Overview:
- Converts the PS/2 set-2 scancode byte stream into held key levels key_space, key_left and key_right.
- The jump control FSM consumes these levels.
- Sits between the PS/2 byte receiver (scan_code/scan_valid) and the game control block, in the 100 MHz domain.
- Handles the make/break (F0) prefix, the extended (E0) prefix, the 8-byte Pause (E1) sequence, and recovery from truncated sequences.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TIMEOUT_CYCLES, 200_000, maximum gap (2 ms) allowed between prefix and code byte before the sequence is abandoned.
- PAUSE_SKIP, 7, number of bytes discarded after an E1 byte.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous reset, active-high.
- scan_code  input  8  byte from the PS/2 receiver; valid only while scan_valid is high.
- scan_valid  input  1  single-cycle strobe, one per received byte.
- key_space  output  1  registered; high while Space (29) is held.
- key_left  output  1  registered; high while Left arrow (E0 6B) is held.
- key_right  output  1  registered; high while Right arrow (E0 74) is held.
- seq_error  output  1  registered one-cycle pulse on a prefix timeout.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all key outputs 0, seq_error 0, state IDLE, all counters 0.
- State set: IDLE, EXT, BRK, EXT_BRK, SKIP.
- Every transition happens only on a cycle with scan_valid=1, except the timeout transition.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP with skip_cnt=PAUSE_SKIP.
  - 29 -> key_space<=1.
  - Any other byte is ignored; stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - 6B -> key_left<=1, go to IDLE.
  - 74 -> key_right<=1, go to IDLE.
  - E0 -> stay in EXT.
  - Any other byte -> IDLE, no key change. This covers fake-shift E0 12.
- BRK:
  - 29 -> key_space<=0, go to IDLE.
  - E0 -> EXT_BRK; both prefix orders are accepted.
  - F0 -> stay in BRK.
  - Any other byte -> IDLE.
- EXT_BRK:
  - 6B -> key_left<=0, go to IDLE.
  - 74 -> key_right<=0, go to IDLE.
  - Any other byte -> IDLE.
- SKIP:
  - Each valid byte decrements skip_cnt, whatever its value (F0/E0 included).
  - When skip_cnt reaches 1 and a byte arrives -> IDLE.
  - No key change during SKIP.
- Latency: a key output changes on the clock edge following the cycle in which the completing byte had scan_valid=1 (1 cycle).
- Timeout:
  - In EXT, BRK, EXT_BRK and SKIP, to_cnt increments every cycle without scan_valid and clears on every scan_valid.
  - When to_cnt reaches TIMEOUT_CYCLES-1: state -> IDLE, to_cnt -> 0, seq_error pulses for 1 cycle, key levels unchanged.
  - to_cnt is held at 0 in IDLE.
  - If scan_valid arrives in the same cycle as the timeout expiry, the byte wins: it is processed and the timeout is discarded.
- Typematic repeats: repeated make codes re-assert an already-high key with no glitch.
- Simultaneous keys: left and right may both be high; there is no priority resolution here, the consumer FSM owns it.
- Break for a key not held: harmless, the output stays 0.
- Reset mid-sequence: all state is cleared and keys drop on the next edge. A subsequent orphan code byte is interpreted from IDLE.
- Counter widths:
  - to_cnt is $clog2(TIMEOUT_CYCLES) bits.
  - skip_cnt is 3 bits.
  - No wrap is possible, because both are bounded by the compare.

Decomposition:
- kbd_pkg holds the scancode localparams (SC_SPACE=8'h29, SC_LEFT=8'h6B, SC_RIGHT=8'h74, SC_EXT=8'hE0, SC_BRK=8'hF0, SC_PAUSE=8'hE1) and the typedef enum logic [2:0] kbd_state_t.
- No sub-module: one FSM with two counters.
- The PS/2 bit receiver remains a separate upstream module.

Test Plan:
- Bytes 29, then F0 29, spaced by 1000 cycles -> key_space goes 0->1 one cycle after the first strobe, and 1->0 one cycle after the 29 of the F0 29 pair.
- E0 6B, E0 74, then E0 F0 6B -> left=1 and right=1 simultaneously, then left=0 with right still 1.
- E0 followed by no byte for TIMEOUT_CYCLES, then 74 -> seq_error pulses once at the timeout, and 74 is ignored (right stays 0).
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 -> no key change during the 8 bytes, key_space=1 after the trailing 29.
- Hold Space (29 repeated ten times, 100 cycles apart) -> key_space stays constantly 1 with no glitch. Break via F0 E0 74 while right is held -> key_right=0.
- rst asserted for 1 cycle between E0 and 6B, with key_space previously high -> all outputs 0 after the edge. The following 6B does not set key_left; the state returns to IDLE.
